// File: rtl/unlock_key_checker.sv
// unlock_key_checker: collects a multi-word unlock key over a valid/ready
// stream, compares it against a fixed key and pulses unlock on a match.
// Failed attempts are counted; repeated failures force a timed lockout and
// a stalled entry is abandoned after an idle timeout.
module unlock_key_checker #(
    parameter int                          DATA_W         = 8,
    parameter int                          KEY_WORDS      = 4,
    parameter logic [DATA_W*KEY_WORDS-1:0] KEY_VALUE      = 32'hA5C30F96,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          LOCKOUT_CYCLES = 16,
    parameter int                          TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           locked_in,
    input  logic                           key_valid,
    input  logic [DATA_W-1:0]              key_data,
    output logic                           key_ready,
    output logic                           unlock,
    output logic                           key_error,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LO_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int FC_W  = $clog2(MAX_FAILS+1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        UNLOCK,
        FAIL,
        LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  word_idx, word_idx_d;
    logic              mismatch, mismatch_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic [LO_W-1:0]   lo_cnt, lo_cnt_d;
    logic [FC_W-1:0]   fail_d;
    logic [FC_W-1:0]   fail_inc;
    logic [DATA_W-1:0] exp_word;
    logic              handshake;
    logic              word_ok;
    logic              last_word;

    // Words are only accepted while the lock is engaged and an entry can be taken.
    assign key_ready = locked_in && (state_q == IDLE || state_q == COLLECT);
    assign handshake = key_valid && key_ready;

    // The most-significant key word is expected first.
    assign exp_word  = KEY_VALUE[(KEY_WORDS-1-int'(word_idx))*DATA_W +: DATA_W];
    assign word_ok   = (key_data == exp_word);
    assign last_word = (word_idx == IDX_W'(KEY_WORDS-1));
    assign fail_inc  = (fail_count == FC_W'(MAX_FAILS)) ? fail_count
                                                        : fail_count + FC_W'(1);

    // Next-state logic: collection, verdict, failure accounting and lockout timing.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx;
        mismatch_d = mismatch;
        to_cnt_d   = to_cnt;
        lo_cnt_d   = lo_cnt;
        fail_d     = fail_count;
        case (state_q)
            IDLE, COLLECT: begin
                if (!locked_in) begin
                    state_d    = IDLE;
                    word_idx_d = '0;
                    mismatch_d = 1'b0;
                    to_cnt_d   = '0;
                end else if (handshake) begin
                    to_cnt_d = '0;
                    if (last_word) begin
                        word_idx_d = '0;
                        mismatch_d = 1'b0;
                        if (!mismatch && word_ok) begin
                            state_d = UNLOCK;
                            fail_d  = '0;
                        end else begin
                            state_d = FAIL;
                            fail_d  = fail_inc;
                        end
                    end else begin
                        state_d    = COLLECT;
                        word_idx_d = word_idx + IDX_W'(1);
                        mismatch_d = mismatch | ~word_ok;
                    end
                end else if (state_q == COLLECT) begin
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES-1)) begin
                        state_d    = FAIL;
                        fail_d     = fail_inc;
                        word_idx_d = '0;
                        mismatch_d = 1'b0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt + TO_W'(1);
                    end
                end
            end
            UNLOCK: begin
                state_d = IDLE;
            end
            FAIL: begin
                lo_cnt_d = '0;
                state_d  = (fail_count == FC_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (lo_cnt == LO_W'(LOCKOUT_CYCLES-1)) begin
                    state_d  = IDLE;
                    lo_cnt_d = '0;
                    fail_d   = '0;
                end else begin
                    lo_cnt_d = lo_cnt + LO_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                word_idx_d = '0;
                mismatch_d = 1'b0;
                to_cnt_d   = '0;
                lo_cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered single-cycle outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            word_idx   <= '0;
            mismatch   <= 1'b0;
            to_cnt     <= '0;
            lo_cnt     <= '0;
            fail_count <= '0;
            unlock     <= 1'b0;
            key_error  <= 1'b0;
            lockout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx   <= word_idx_d;
            mismatch   <= mismatch_d;
            to_cnt     <= to_cnt_d;
            lo_cnt     <= lo_cnt_d;
            fail_count <= fail_d;
            unlock     <= (state_d == UNLOCK);
            key_error  <= (state_d == FAIL);
            lockout    <= (state_d == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_unlock_key_checker.sv
// tb_unlock_key_checker: scoreboard bench for unlock_key_checker. Each key
// attempt pushes its expected pulse (kind and latency from the last accepted
// word) into a queue; a negedge monitor pops and compares when a pulse appears.
module tb_unlock_key_checker;

    localparam logic [31:0] GOOD_KEY  = 32'hA5C30F96;
    localparam logic [31:0] BAD_KEY   = 32'hA5C30096;
    localparam int          MAX_FAILS = 3;
    localparam int          LOCK_LEN  = 16;
    localparam int          TIMEOUT   = 64;
    localparam int          EV_UNLOCK = 1;
    localparam int          EV_ERROR  = 2;

    logic       clk;
    logic       resetn;
    logic       locked_in;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       unlock;
    logic       key_error;
    logic       lockout;
    logic [1:0] fail_count;

    typedef struct {
        int code;
        int lat;
    } exp_t;

    exp_t expQ[$];
    int   checkCount  = 0;
    int   errorCount  = 0;
    int   cyc         = 0;
    int   lastHs      = 0;
    int   lockRun     = 0;
    int   lastLockRun = 0;
    int   expFail     = 0;

    unlock_key_checker dut (
        .clk        (clk),
        .resetn     (resetn),
        .locked_in  (locked_in),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .unlock     (unlock),
        .key_error  (key_error),
        .lockout    (lockout),
        .fail_count (fail_count)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure pulse latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Monitor: scoreboard pops on pulses, tracks handshakes and lockout length.
    always @(negedge clk) begin
        exp_t e;
        int   got;
        if (!resetn) begin
            lockRun = 0;
        end else begin
            if (unlock || key_error) begin
                got = (int'(key_error) << 1) | int'(unlock);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", got, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulse_kind", got, e.code);
                    checkOutput("pulse_latency", cyc - lastHs, e.lat);
                end
            end
            if (key_valid && key_ready) lastHs = cyc;
            if (lockout) begin
                lockRun++;
                checkOutput("ready_in_lockout", int'(key_ready), 0);
            end else if (lockRun != 0) begin
                lastLockRun = lockRun;
                lockRun = 0;
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sendWord(input logic [7:0] d);
        bit done;
        done      = 1'b0;
        key_valid = 1'b1;
        key_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = key_ready;
            stepCycle();
        end
        key_valid = 1'b0;
        if (!done) checkOutput("word_accept_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("pulse_timeout", expQ.size(), 0);
            expQ.delete();
        end
        stepCycle();
    endtask

    // Send the first nWords of key, then check the pulse and the resulting fail count.
    task automatic applyStimulus(input logic [31:0] key, input int nWords,
                                 input int code, input int lat);
        exp_t e;
        e.code = code;
        e.lat  = lat;
        expQ.push_back(e);
        for (int w = 0; w < nWords; w++) sendWord(key[31-8*w -: 8]);
        waitDrain();
        if (code == EV_UNLOCK) expFail = 0;
        else if (expFail < MAX_FAILS) expFail++;
        checkOutput("fail_count", int'(fail_count), expFail);
    endtask

    task automatic waitLockoutEnd();
        int n;
        n = 0;
        while (lockout && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput("lockout_ends", int'(lockout), 0);
        @(negedge clk);
        #1;
        checkOutput("lockout_length", lastLockRun, LOCK_LEN);
        checkOutput("ready_after_lockout", int'(key_ready), 1);
        checkOutput("fail_after_lockout", int'(fail_count), 0);
        expFail = 0;
        stepCycle();
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        locked_in = 1'b1;
        key_valid = 1'b0;
        key_data  = 8'h00;
        #1;
        checkOutput("reset_unlock", int'(unlock), 0);
        checkOutput("reset_key_error", int'(key_error), 0);
        checkOutput("reset_lockout", int'(lockout), 0);
        checkOutput("reset_fail_count", int'(fail_count), 0);
        checkOutput("reset_key_ready", int'(key_ready), 1);
        stepCycle();
        stepCycle();
        resetn = 1'b1;
        stepCycle();

        $display("[TB] correct key");
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        $display("[TB] wrong key");
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        $display("[TB] lockout after repeated failures");
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        applyStimulus(32'h00000000, 4, EV_ERROR, 1);
        applyStimulus(32'h96A5C30F, 4, EV_ERROR, 1);
        checkOutput("lockout_active", int'(lockout), 1);
        checkOutput("ready_during_lockout", int'(key_ready), 0);
        waitLockoutEnd();
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        $display("[TB] timeout on stalled entry");
        applyStimulus(GOOD_KEY, 2, EV_ERROR, TIMEOUT + 1);
        checkOutput("ready_after_timeout", int'(key_ready), 1);
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        $display("[TB] locked_in control");
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        locked_in = 1'b0;
        #1;
        checkOutput("ready_unlocked", int'(key_ready), 0);
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_data  = GOOD_KEY[31-8*(i%4) -: 8];
            stepCycle();
        end
        key_valid = 1'b0;
        locked_in = 1'b1;
        stepCycle();
        sendWord(8'hA5);
        sendWord(8'hC3);
        key_valid = 1'b1;
        key_data  = 8'h0F;
        locked_in = 1'b0;
        @(negedge clk);
        checkOutput("ready_on_abort", int'(key_ready), 0);
        stepCycle();
        key_valid = 1'b0;
        locked_in = 1'b1;
        stepCycle();
        checkOutput("fail_after_abort", int'(fail_count), expFail);
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        $display("[TB] reset during lockout");
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        applyStimulus(BAD_KEY, 4, EV_ERROR, 1);
        begin
            bit reached;
            reached = 1'b0;
            for (int n = 0; n < 50 && !reached; n++) begin
                @(negedge clk);
                #1;
                reached = (lockRun == 5);
            end
            checkOutput("lockout_cycle5_reached", int'(reached), 1);
        end
        checkOutput("fail_before_reset", int'(fail_count), MAX_FAILS);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_lockout", int'(lockout), 0);
        checkOutput("async_reset_fail_count", int'(fail_count), 0);
        checkOutput("async_reset_ready", int'(key_ready), 1);
        expFail = 0;
        stepCycle();
        resetn = 1'b1;
        stepCycle();
        applyStimulus(GOOD_KEY, 4, EV_UNLOCK, 1);

        repeat (3) stepCycle();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/unlock_key_checker.md
Name: unlock_key_checker

Overview:
- Upstream feeder of the power-on lock register. It accepts a multi-word unlock key over a valid/ready stream and compares it against a fixed key.
- On a correct key it issues a single-cycle unlock pulse, which drives the lock register's unlock input.
- It counts failed attempts, aborts stalled entries with a timeout, and enforces a timed lockout after repeated failures.

Parameters:
- DATA_W, 8: key word width in bits.
- KEY_WORDS, 4: number of words per key.
- KEY_VALUE, 32'hA5C30F96: expected key, DATA_W*KEY_WORDS bits, most-significant word entered first.
- MAX_FAILS, 3: failed attempts that trigger lockout.
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles.
- TIMEOUT_CYCLES, 64: maximum idle gap between words during collection.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- locked_in  in  1  current lock state from the lock register (1 = locked).
- key_valid  in  1  key word valid.
- key_data  in  DATA_W  key word.
- key_ready  out  1  word accepted when key_valid && key_ready.
- unlock  out  1  single-cycle unlock pulse to the lock register.
- key_error  out  1  single-cycle pulse on a failed attempt.
- lockout  out  1  high while in lockout.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failed attempts.

Behaviour:
- Reset (resetn low, async): state IDLE; word index, mismatch flag, timeout counter and lockout counter cleared. Outputs: unlock=0, key_error=0, lockout=0, fail_count=0. key_ready follows its combinational rule (below).
- key_ready = locked_in && (state==IDLE || state==COLLECT). It is combinational from registered state.
- States: IDLE, COLLECT, UNLOCK, FAIL, LOCKOUT.
- IDLE:
  - A handshake compares word 0 and goes to COLLECT with index=1.
  - If KEY_WORDS==1, it evaluates immediately, as for the last word.
- COLLECT:
  - Each handshake compares key_data against word[index], i.e. KEY_VALUE[DATA_W*(KEY_WORDS-index)-1 -: DATA_W].
  - A difference sets a sticky mismatch flag.
  - No early reject: all KEY_WORDS words are always accepted, giving equal timing for right and wrong keys.
- Last-word handshake: next state is UNLOCK if the mismatch flag is clear and the last word matches; otherwise FAIL.
- UNLOCK:
  - unlock=1 for exactly one cycle, the cycle after the last handshake.
  - fail_count cleared to 0; return to IDLE.
- FAIL:
  - key_error=1 for one cycle; fail_count increments, saturating at MAX_FAILS.
  - If the new count equals MAX_FAILS, go to LOCKOUT; else go to IDLE.
- LOCKOUT:
  - lockout=1 and key_ready=0 for LOCKOUT_CYCLES cycles, counted from the first LOCKOUT cycle.
  - fail_count holds MAX_FAILS during lockout.
  - On exit: IDLE with fail_count=0.
  - LOCKOUT runs to completion regardless of locked_in.
- Timeout:
  - The counter increments each COLLECT cycle without a handshake and clears on every handshake.
  - On TIMEOUT_CYCLES consecutive idle cycles, the partial key is discarded and the state goes to FAIL, counting as a failed attempt.
- locked_in low while in IDLE/COLLECT: abort to IDLE next cycle. Partial key discarded; fail_count and key_error unaffected.
- Simultaneous events: a handshake in the same cycle the timeout would fire takes priority, so no timeout occurs. locked_in low takes priority over a handshake in the same cycle; that word is not accepted (key_ready=0).
- Mid-operation reset clears everything at once, including fail_count and lockout.
- unlock and key_error are never high in the same cycle.
- Both pulses are registered outputs, one cycle wide.

Test Plan:
1. Correct key: locked_in=1; words A5,C3,0F,96 on consecutive cycles -> 4 handshakes; unlock=1 for exactly one cycle, one cycle after the 4th handshake; key_error=0; fail_count=0.
2. Wrong key: words A5,C3,00,96 -> all 4 accepted; key_error pulse one cycle after the 4th handshake; fail_count=1; unlock never asserted.
3. Lockout: three wrong keys -> fail_count 1,2,3; lockout=1 and key_ready=0 for 16 cycles; then key_ready=1 and fail_count=0. A correct key afterwards unlocks.
4. Timeout: send A5,C3, then hold key_valid=0 for 64 cycles -> key_error pulse; fail_count=1; state IDLE. A following full correct key unlocks and clears fail_count to 0.
5. locked_in control: locked_in=0 -> key_ready=0, with no unlock or key_error under any key_valid activity. Drop locked_in after 2 words -> IDLE, fail_count unchanged.
6. Reset: drive resetn low during cycle 5 of lockout with fail_count=3 -> lockout=0 and fail_count=0 immediately (async). After release, a correct key unlocks.
